// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arb_pkg                                                         |
// | Shared priority encoding and default sizes for the dmem arbiter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ST_CPU_PRI = 1'b0,
    ST_EXT_PRI = 1'b1
  } prio_e;

  localparam int unsigned c_def_aw        = 32;
  localparam int unsigned c_def_dw        = 32;
  localparam int unsigned c_def_max_burst = 4;

  // Burst counter width; a one-grant burst still needs a 1-bit register.
  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter_if                                                      |
// | CPU, external-master and data-memory signals seen by the arbiter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = c_def_aw,
  parameter int DW = c_def_dw
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic [DW-1:0] ext_rdata;
  logic          ext_rvalid;

  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rd,
    output cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_we, mem_a, mem_wd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rd,
    input  cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_we, mem_a, mem_wd
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter                                                         |
// | Two-requester data-memory arbiter with bounded-burst fair priority.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = c_def_aw,
  parameter int DW        = c_def_dw,
  parameter int MAX_BURST = c_def_max_burst
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned      c_cw       = cnt_width(MAX_BURST);
  localparam logic [c_cw-1:0]  c_cnt_last = c_cw'(MAX_BURST - 1);

  prio_e           r_prio;
  prio_e           w_prio_nxt;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_cnt_nxt;

  logic            w_contend;
  logic            w_cpu_gnt;
  logic            w_ext_gnt;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_a;
  logic [DW-1:0]   w_mem_wd;

  logic [DW-1:0]   r_cpu_rdata;
  logic [DW-1:0]   r_ext_rdata;
  logic            r_cpu_rvalid;
  logic            r_ext_rvalid;

  always_comb begin
    w_contend  = bus.cpu_req & bus.ext_req;
    w_cpu_gnt  = 1'b0;
    w_ext_gnt  = 1'b0;
    w_prio_nxt = r_prio;
    w_cnt_nxt  = '0;
    w_mem_we   = 1'b0;
    w_mem_a    = bus.cpu_addr;
    w_mem_wd   = bus.cpu_wdata;

    // Grants are masked while reset is held so nothing reaches memory.
    if (!reset) begin
      if (bus.cpu_req && (!bus.ext_req || r_prio == ST_CPU_PRI)) begin
        w_cpu_gnt = 1'b1;
      end else if (bus.ext_req) begin
        w_ext_gnt = 1'b1;
      end
    end

    if (w_ext_gnt) begin
      w_mem_we = bus.ext_we;
      w_mem_a  = bus.ext_addr;
      w_mem_wd = bus.ext_wdata;
    end else if (w_cpu_gnt) begin
      w_mem_we = bus.cpu_we;
    end

    // Only contended grants count towards the burst limit.
    if (w_contend) begin
      if (r_cnt == c_cnt_last) begin
        w_prio_nxt = (r_prio == ST_CPU_PRI) ? ST_EXT_PRI : ST_CPU_PRI;
        w_cnt_nxt  = '0;
      end else begin
        w_cnt_nxt  = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio       <= ST_CPU_PRI;
      r_cnt        <= '0;
      r_cpu_rvalid <= 1'b0;
      r_ext_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ext_rdata  <= '0;
    end else begin
      r_prio       <= w_prio_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cpu_rvalid <= w_cpu_gnt & ~bus.cpu_we;
      r_ext_rvalid <= w_ext_gnt & ~bus.ext_we;
      if (w_cpu_gnt && !bus.cpu_we) begin
        r_cpu_rdata <= bus.mem_rd;
      end
      if (w_ext_gnt && !bus.ext_we) begin
        r_ext_rdata <= bus.mem_rd;
      end
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.ext_gnt    = w_ext_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_gnt & ~reset;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.ext_rdata  = r_ext_rdata;
  assign bus.ext_rvalid = r_ext_rvalid;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_a      = w_mem_a;
  assign bus.mem_wd     = w_mem_wd;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter                                                      |
// | Table, directed and random checks of dmem_arbiter against a model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int c_mb = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus  ();
  dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(c_mb)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic [31:0] mem [256];
  assign bus.mem_rd  = mem[bus.mem_a[7:0]];
  assign bus1.mem_rd = 32'h0;
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[7:0]] <= bus.mem_wd;

  int nchk  = 0;
  int npass = 0;

  // Reference model: who is favoured, and how many contended grants in a row.
  int          m_fav;     // 1 = CPU, 2 = EXT
  int          m_streak;
  logic        m_crv, m_erv;
  logic [31:0] m_crd, m_erd;
  logic [31:0] m_mem [256];

  typedef struct {
    logic cr; logic cw; logic [31:0] ca; logic [31:0] cd;
    logic er; logic ew; logic [31:0] ea; logic [31:0] ed;
    logic xcg; logic xeg; logic xwe; logic xst; logic xcrv; logic xerv;
    logic [31:0] xcrd;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int winner();
    if (bus.cpu_req && bus.ext_req) return m_fav;
    if (bus.cpu_req) return 1;
    if (bus.ext_req) return 2;
    return 0;
  endfunction

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.ext_req = er; bus.ext_we = ew; bus.ext_addr = ea; bus.ext_wdata = ed;
    #2;
  endtask

  task automatic model_check();
    int w;
    logic xwe;
    logic [31:0] xa, xd;
    w   = winner();
    xwe = (w == 1) ? bus.cpu_we : (w == 2) ? bus.ext_we : 1'b0;
    xa  = (w == 2) ? bus.ext_addr  : bus.cpu_addr;
    xd  = (w == 2) ? bus.ext_wdata : bus.cpu_wdata;
    check("cpu_gnt",    bus.cpu_gnt,    w == 1);
    check("ext_gnt",    bus.ext_gnt,    w == 2);
    check("cpu_stall",  bus.cpu_stall,  bus.cpu_req && w != 1);
    check("mem_we",     bus.mem_we,     xwe);
    check("mem_a",      bus.mem_a,      xa);
    check("mem_wd",     bus.mem_wd,     xd);
    check("cpu_rvalid", bus.cpu_rvalid, m_crv);
    check("ext_rvalid", bus.ext_rvalid, m_erv);
    check("cpu_rdata",  bus.cpu_rdata,  m_crd);
    check("ext_rdata",  bus.ext_rdata,  m_erd);
  endtask

  task automatic advance();
    int w;
    w = winner();
    m_crv = (w == 1) && !bus.cpu_we;
    m_erv = (w == 2) && !bus.ext_we;
    if (m_crv) m_crd = m_mem[bus.cpu_addr[7:0]];
    if (m_erv) m_erd = m_mem[bus.ext_addr[7:0]];
    if (w == 1 && bus.cpu_we) m_mem[bus.cpu_addr[7:0]] = bus.cpu_wdata;
    if (w == 2 && bus.ext_we) m_mem[bus.ext_addr[7:0]] = bus.ext_wdata;
    if (bus.cpu_req && bus.ext_req) begin
      m_streak++;
      if (m_streak == c_mb) begin
        m_fav    = 3 - m_fav;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_fav = 1; m_streak = 0; m_crv = 0; m_erv = 0; m_crd = 0; m_erd = 0;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
    bus1.ext_req = 0; bus1.ext_we = 0; bus1.ext_addr = 0; bus1.ext_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = (i * 32'h01010101) ^ 32'hA5A50000;
      m_mem[i] = (i * 32'h01010101) ^ 32'hA5A50000;
    end
    mem[8'h10]   = 32'hDEADBEEF;
    m_mem[8'h10] = 32'hDEADBEEF;
    model_reset();

    // Outputs held quiet while reset is active even with both requesting.
    drive(1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h55);
    check("rst_cpu_gnt",    bus.cpu_gnt,    0);
    check("rst_ext_gnt",    bus.ext_gnt,    0);
    check("rst_mem_we",     bus.mem_we,     0);
    check("rst_cpu_stall",  bus.cpu_stall,  0);
    check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    check("rst_cpu_rdata",  bus.cpu_rdata,  0);
    do_reset();

    tbl[0] = '{1,0,32'h10,0,          0,0,0,0,                    1,0,0,0,0,0,32'h0};
    tbl[1] = '{0,0,0,0,               0,0,0,0,                    0,0,0,0,1,0,32'hDEADBEEF};
    tbl[2] = '{0,0,0,0,               1,1,32'h20,32'h12345678,    0,1,1,0,0,0,32'hDEADBEEF};
    tbl[3] = '{1,0,32'h20,0,          0,0,0,0,                    1,0,0,0,0,0,32'hDEADBEEF};
    tbl[4] = '{0,0,0,0,               0,0,0,0,                    0,0,0,0,1,0,32'h12345678};
    tbl[5] = '{1,0,32'h10,0,          1,0,32'h20,0,               1,0,0,0,0,0,32'h12345678};
    tbl[6] = '{1,1,32'h30,32'hCAFEF00D,0,0,0,0,                   1,0,1,0,1,0,32'hDEADBEEF};
    tbl[7] = '{0,0,0,0,               0,0,0,0,                    0,0,0,0,0,0,32'hDEADBEEF};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].er, tbl[i].ew, tbl[i].ea, tbl[i].ed);
      model_check();
      check($sformatf("tbl%0d_cpu_gnt", i),    bus.cpu_gnt,    tbl[i].xcg);
      check($sformatf("tbl%0d_ext_gnt", i),    bus.ext_gnt,    tbl[i].xeg);
      check($sformatf("tbl%0d_mem_we", i),     bus.mem_we,     tbl[i].xwe);
      check($sformatf("tbl%0d_cpu_stall", i),  bus.cpu_stall,  tbl[i].xst);
      check($sformatf("tbl%0d_cpu_rvalid", i), bus.cpu_rvalid, tbl[i].xcrv);
      check($sformatf("tbl%0d_ext_rvalid", i), bus.ext_rvalid, tbl[i].xerv);
      check($sformatf("tbl%0d_cpu_rdata", i),  bus.cpu_rdata,  tbl[i].xcrd);
      advance();
    end

    // Continuous contention from reset: CPU x4, EXT x4, CPU x4.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(1, 0, 32'(c), 0, 1, 0, 32'(c + 8'h40), 0);
      model_check();
      check($sformatf("burst%0d_cpu_gnt", c),   bus.cpu_gnt,   ((c / 4) % 2) == 0);
      check($sformatf("burst%0d_cpu_stall", c), bus.cpu_stall, ((c / 4) % 2) == 1);
      advance();
    end

    // Reset in the middle of an EXT burst (two EXT grants taken).
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, 32'(c), 0, 1, 0, 32'(c + 8'h80), 0);
      model_check();
      advance();
    end
    drive(1, 0, 32'h5, 0, 1, 0, 32'h85, 0);
    check("pre_rst_ext_gnt", bus.ext_gnt, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_cpu_gnt",    bus.cpu_gnt,    0);
    check("mid_rst_ext_gnt",    bus.ext_gnt,    0);
    check("mid_rst_mem_we",     bus.mem_we,     0);
    check("mid_rst_cpu_stall",  bus.cpu_stall,  0);
    check("mid_rst_ext_rvalid", bus.ext_rvalid, 0);
    check("mid_rst_ext_rdata",  bus.ext_rdata,  0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    drive(1, 0, 32'h5, 0, 1, 0, 32'h85, 0);
    model_check();
    check("post_rst_cpu_wins", bus.cpu_gnt, 1);
    advance();

    // EXT alone for ten cycles leaves the burst count untouched.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 0, 1, 0, 32'(c + 8'hA0), 0);
      model_check();
      check($sformatf("solo%0d_ext_gnt", c), bus.ext_gnt, 1);
      advance();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 32'(c), 0, 1, 0, 32'(c + 8'hB0), 0);
      model_check();
      check($sformatf("after_solo%0d_cpu_gnt", c), bus.cpu_gnt, c < 4);
      advance();
    end

    // One-grant bursts alternate strictly.
    do_reset();
    bus1.cpu_req = 1; bus1.ext_req = 1;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_check();
      check($sformatf("alt%0d_cpu_gnt", k), bus1.cpu_gnt, (k % 2) == 0);
      check($sformatf("alt%0d_ext_gnt", k), bus1.ext_gnt, (k % 2) == 1);
      advance();
    end
    bus1.cpu_req = 0; bus1.ext_req = 0;

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            32'($urandom_range(0, 255)), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            32'($urandom_range(0, 255)), $urandom);
      model_check();
      check("rand_one_hot_gnt", bus.cpu_gnt & bus.ext_gnt, 0);
      advance();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
